load_store_unit: RTL

//  Initiator side of the core's data-memory port: takes one load/store request at a time from the

---
 rtl/load_store_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide memory with 1-cycle registered reads.
// Sub-word stores are read-modify-write. Define LSU_MISALIGN_CHECK_EN to fault on misaligned H/W accesses.
module load_store_unit #(
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req,
    input  logic         i_we,
    input  logic [2:0]   i_funct3,
    input  logic [D-1:0] i_addr,
    input  logic [31:0]  i_wdata,
    output logic         o_ready,
    output logic         o_done,
    output logic [31:0]  o_rdata,
    output logic         o_fault,
    output logic [D-1:0] o_mem_addr,
    output logic [31:0]  o_mem_data,
    output logic         o_mem_read,
    output logic         o_mem_write,
    input  logic [31:0]  i_mem_data
);

    typedef enum logic [2:0] {IDLE, RD, LD_DATA, MERGE, WR, RESP} state_t;

    typedef struct packed {
        logic         we;
        logic [2:0]   funct3;
        logic [D-1:0] addr;
        logic [31:0]  wdata;
    } req_t;

    state_t       state, state_n;
    req_t         req;
    logic         f3_ok, misalign, fault_dec;
    logic [D-1:0] addr_eff;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [31:0]  ld_ext, st_merge;

    // Request decode: legality, and either alignment faulting or silent align-down.
    always_comb begin
        f3_ok    = i_we ? (i_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign = 1'b0;
        addr_eff = i_addr;
`ifdef LSU_MISALIGN_CHECK_EN
        if (i_funct3[1:0] == 2'b01)      misalign = i_addr[0];
        else if (i_funct3[1:0] == 2'b10) misalign = |i_addr[1:0];
`else
        if (i_funct3[1:0] == 2'b01)      addr_eff[0]   = 1'b0;
        else if (i_funct3[1:0] == 2'b10) addr_eff[1:0] = 2'b00;
`endif
        fault_dec = !f3_ok || misalign;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (i_req) begin
                    if (fault_dec)                           state_n = RESP;
                    else if (i_we && i_funct3[1:0] == 2'b10) state_n = WR;
                    else                                     state_n = RD;
                end
            end
            RD:      state_n = req.we ? MERGE : LD_DATA;
            LD_DATA: state_n = RESP;
            MERGE:   state_n = WR;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes come straight from the state register so nothing from i_* reaches memory combinationally.
    assign o_ready     = (state == IDLE);
    assign o_done      = (state == RESP);
    assign o_mem_read  = (state == RD);
    assign o_mem_write = (state == WR);

    // Lane extraction for loads, lane replacement for sub-word stores (little-endian).
    always_comb begin
        ld_byte  = i_mem_data[{req.addr[1:0], 3'b000} +: 8];
        ld_half  = i_mem_data[{req.addr[1], 4'b0000} +: 16];
        case (req.funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = i_mem_data;
        endcase
        st_merge = i_mem_data;
        case (req.funct3[1:0])
            2'b00:   st_merge[{req.addr[1:0], 3'b000} +: 8] = req.wdata[7:0];
            2'b01:   st_merge[{req.addr[1], 4'b0000} +: 16] = req.wdata[15:0];
            default: st_merge = req.wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            req        <= '0;
            o_rdata    <= '0;
            o_fault    <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req) begin
                        req        <= '{we: i_we, funct3: i_funct3, addr: addr_eff, wdata: i_wdata};
                        o_mem_addr <= addr_eff;
                        o_fault    <= fault_dec;
                        if (i_we) o_mem_data <= i_wdata;
                    end
                end
                LD_DATA: o_rdata    <= ld_ext;
                MERGE:   o_mem_data <= st_merge;
                default: ;
            endcase
        end
    end

endmodule
